// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
//
// Round-robin scheduler that shares a single uart_tx between NUM_REQ byte
// requesters. The winning requester's byte is placed on tx_data together with
// a one-cycle tx_start pulse. The scheduler then follows uart_tx's active flag
// through the frame and inserts an idle gap before it issues the next grant.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   req          per-requester request, held until the matching gnt bit
//   req_data     packed request bytes, requester i on [8*i+7:8*i]
//   gnt          one-hot, one-cycle pulse: byte of requester i accepted
//   done         one-hot, one-cycle pulse: frame of requester i finished
//   tx_start     one-cycle start pulse to uart_tx
//   tx_data      byte to uart_tx, held from tx_start until the next grant
//   tx_active    uart_tx busy flag
//   cur_id       index of the requester currently or last served
//   busy         high whenever the scheduler is not idle
//   err_timeout  one-cycle pulse when tx_active never rose after tx_start
// ---------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_active,
  output logic [2:0]             cur_id,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_ACT = 2'd1;
  localparam logic [1:0] S_SENDING  = 2'd2;
  localparam logic [1:0] S_GAP      = 2'd3;

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int SUM_W   = IDX_W + 1;
  // One counter serves both the ack wait and the gap, so size it for the larger.
  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [1:0]         state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [IDX_W-1:0]   last_id_q,  last_id_d;
  logic [2:0]         cur_id_q,   cur_id_d;
  logic [7:0]         tx_data_q,  tx_data_d;
  logic [NUM_REQ-1:0] gnt_q,      gnt_d;
  logic [NUM_REQ-1:0] done_q,     done_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q,     busy_d;
  logic               err_q,      err_d;

  // -------------------------------------------------------------------------
  // Rotating candidate list: candidate gi is requester (last_id + 1 + gi)
  // mod NUM_REQ, so candidate 0 is the highest-priority one this round.
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;
  logic [7:0]         req_byte [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [SUM_W-1:0] sum;
      assign sum          = {1'b0, last_id_q} + SUM_W'(gi + 1);
      // sum never exceeds 2*NUM_REQ-1, so a single subtract is the modulo
      assign cand_idx[gi] = (sum >= SUM_W'(NUM_REQ)) ? IDX_W'(sum - SUM_W'(NUM_REQ))
                                                     : sum[IDX_W-1:0];
      assign cand_hit[gi] = req[cand_idx[gi]];
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    // Scan from lowest priority upward so the first hit in rotation order wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_id_d  = last_id_q;
    cur_id_d   = cur_id_q;
    tx_data_d  = tx_data_q;
    gnt_d      = '0;
    done_d     = '0;
    tx_start_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A busy transmitter (foreign or late activity) blocks the launch.
        if (win_found && !tx_active) begin
          tx_data_d              = req_byte[win_idx];
          tx_start_d             = 1'b1;
          gnt_d[win_idx]         = 1'b1;
          cur_id_d               = '0;
          cur_id_d[IDX_W-1:0]    = win_idx;
          last_id_d              = win_idx;
          cnt_d                  = '0;
          state_d                = S_WAIT_ACT;
        end
      end

      S_WAIT_ACT: begin
        // tx_active takes precedence over the limit check, so a rise on the
        // last allowed cycle is still accepted.
        if (tx_active) begin
          state_d = S_SENDING;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SENDING: begin
        if (!tx_active) begin
          done_d[last_id_q] = 1'b1;
          cnt_d             = '0;
          state_d           = S_GAP;
        end
      end

      S_GAP: begin
        // A zero-length gap still spends one cycle here.
        if ((GAP_CYCLES == 0) || (cnt_q == CNT_W'(GAP_CYCLES - 1))) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_id_q  <= IDX_W'(NUM_REQ - 1);
      cur_id_q   <= '0;
      tx_data_q  <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_id_q  <= last_id_d;
      cur_id_q   <= cur_id_d;
      tx_data_q  <= tx_data_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign cur_id      = cur_id_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
//
// Randomized bench for uart_tx_sched. The bench plays both the requesters and
// a simplified uart_tx (tx_active rises a chosen number of cycles after
// tx_start and stays high for a random frame length, or never rises). For
// each transaction the expected timeline of gnt/tx_start/done/err_timeout/busy
// is derived from the scheduler's latency rules and checked cycle by cycle;
// the expected winner comes from a plain round-robin search over the request
// vector.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

  localparam int NUM_REQ     = 4;
  localparam int GAP_CYCLES  = 2;
  localparam int ACK_TIMEOUT = 8;
  localparam int N_TXN       = 40;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NUM_REQ-1:0]   req = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic                 tx_active = 1'b0;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic [2:0]           cur_id;
  logic                 busy;
  logic                 err_timeout;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .NUM_REQ     (NUM_REQ),
    .GAP_CYCLES  (GAP_CYCLES),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .done        (done),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_active   (tx_active),
    .cur_id      (cur_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference state: requester view and the last served requester.
  logic [NUM_REQ-1:0] req_vec;
  logic [7:0]         bytes [NUM_REQ];
  int                 mdl_last;
  int                 cur_w;
  logic [7:0]         cur_byte;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int w);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  task automatic drive_req();
    req = req_vec;
    for (int i = 0; i < NUM_REQ; i++) req_data[8*i +: 8] = bytes[i];
  endtask

  // Check one cycle's outputs mid-cycle, then advance to just after the next edge.
  task automatic step(input logic [NUM_REQ-1:0] e_gnt, input logic [NUM_REQ-1:0] e_done,
                      input logic e_start, input logic e_err, input logic e_busy);
    @(negedge clk);
    chk("gnt",         32'(gnt),         32'(e_gnt));
    chk("done",        32'(done),        32'(e_done));
    chk("tx_start",    32'(tx_start),    32'(e_start));
    chk("err_timeout", 32'(err_timeout), 32'(e_err));
    chk("busy",        32'(busy),        32'(e_busy));
    chk("tx_data",     32'(tx_data),     32'(cur_byte));
    chk("cur_id",      32'(cur_id),      32'(cur_w));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int  blk;
    int  r;
    int  flen;
    int  w;
    int  d;
    int  g;
    logic tmo;
    logic [NUM_REQ-1:0] req_snap;

    g = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
    for (int i = 0; i < NUM_REQ; i++) bytes[i] = 8'h00;
    req_vec  = '0;
    mdl_last = NUM_REQ - 1;
    cur_w    = 0;
    cur_byte = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    step('0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    for (int k = 0; k < N_TXN; k++) begin
      // Requests change only while the scheduler is idle.
      if (k < 5) begin
        if (k == 0) for (int i = 0; i < NUM_REQ; i++) bytes[i] = 8'($urandom);
        req_vec = '1;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!req_vec[i] && ($urandom_range(0, 2) == 0)) begin
            req_vec[i] = 1'b1;
            bytes[i]   = 8'($urandom);
          end
        end
        if (k % 6 == 4) begin
          d = int'($urandom_range(0, NUM_REQ - 1));
          req_vec[d] = 1'b0;
        end
        if (req_vec == '0) begin
          d = int'($urandom_range(0, NUM_REQ - 1));
          req_vec[d] = 1'b1;
          bytes[d]   = 8'($urandom);
        end
      end
      drive_req();

      // Optional blocked launch: tx_active held high while idle.
      blk = (k % 5 == 2) ? 3 : 0;
      for (int b = 0; b <= blk; b++) begin
        tx_active = (b < blk);
        step('0, '0, 1'b0, 1'b0, 1'b0);
      end

      req_snap = req_vec;
      w        = pick(req_vec, mdl_last);
      mdl_last = w;
      cur_w    = w;
      cur_byte = bytes[w];
      if (k < 5) chk("fair_order", 32'(w), 32'(k % NUM_REQ));

      // Grant cycle; the winner may keep requesting (re-arbitrated fairly).
      if (k >= 5 && ($urandom_range(0, 1) == 1)) req_vec[w] = 1'b0;
      drive_req();
      step(onehot(w), '0, 1'b1, 1'b0, 1'b1);

      if (k % 7 == 3)      r = ACK_TIMEOUT;
      else if (k % 7 == 5) r = ACK_TIMEOUT - 1;
      else                 r = int'($urandom_range(1, ACK_TIMEOUT - 1));
      tmo  = (r >= ACK_TIMEOUT);
      flen = int'($urandom_range(3, 12));

      for (int j = 1; j < r; j++) step('0, '0, 1'b0, 1'b0, 1'b1);
      if (!tmo) begin
        tx_active = 1'b1;
        for (int j = 0; j < flen; j++) step('0, '0, 1'b0, 1'b0, 1'b1);
        tx_active = 1'b0;
        step('0, '0, 1'b0, 1'b0, 1'b1);
        step('0, onehot(w), 1'b0, 1'b0, 1'b1);
      end else begin
        step('0, '0, 1'b0, 1'b1, 1'b1);
      end
      for (int j = 1; j < g; j++) step('0, '0, 1'b0, 1'b0, 1'b1);

      $display("txn %0d: req=%b blk=%0d winner=%0d byte=%02h ack_dly=%0d frame=%0d %s",
               k, req_snap, blk, w, bytes[w], r, flen, tmo ? "timeout" : "done");
    end

    // Reset in the middle of a frame
    req_vec  = '0;
    req_vec[1] = 1'b1;
    bytes[1] = 8'h3C;
    drive_req();
    step('0, '0, 1'b0, 1'b0, 1'b0);
    w        = pick(req_vec, mdl_last);
    mdl_last = w;
    cur_w    = w;
    cur_byte = bytes[w];
    req_vec[w] = 1'b0;
    drive_req();
    step(onehot(w), '0, 1'b1, 1'b0, 1'b1);
    tx_active = 1'b1;
    step('0, '0, 1'b0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_gnt",      32'(gnt),         32'd0);
    chk("rst_done",     32'(done),        32'd0);
    chk("rst_tx_start", 32'(tx_start),    32'd0);
    chk("rst_tx_data",  32'(tx_data),     32'd0);
    chk("rst_cur_id",   32'(cur_id),      32'd0);
    chk("rst_busy",     32'(busy),        32'd0);
    chk("rst_err",      32'(err_timeout), 32'd0);
    tx_active = 1'b0;
    req_vec   = '0;
    req_vec[0] = 1'b1;
    req_vec[2] = 1'b1;
    bytes[0]  = 8'hA1;
    bytes[2]  = 8'hC3;
    drive_req();
    mdl_last  = NUM_REQ - 1;
    cur_w     = 0;
    cur_byte  = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step('0, '0, 1'b0, 1'b0, 1'b0);
    w        = pick(req_vec, mdl_last);
    mdl_last = w;
    cur_w    = w;
    cur_byte = bytes[w];
    req_vec[w] = 1'b0;
    drive_req();
    step(onehot(w), '0, 1'b1, 1'b0, 1'b1);
    $display("txn reset: req=0101 winner=%0d byte=%02h", w, bytes[w]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one uart_tx instance between NUM_REQ byte requesters.
- Selects a requester, loads its byte onto the uart_tx data input and issues a one-cycle start pulse.
- Tracks the transmitter's active flag through the frame, then enforces an inter-frame gap before the next grant.
- Sits between client logic and uart_tx. It drives uart_tx start/data and observes uart_tx active.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- GAP_CYCLES, 2, idle clk cycles inserted after each frame (0 allowed).
- ACK_TIMEOUT, 8, max clk cycles to wait for tx_active to rise after tx_start before flagging an error; must be >= 3.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request; held until the matching gnt bit.
- req_data  in  8*NUM_REQ  packed bytes; requester i uses bits [8*i+7:8*i]; must be stable while req[i] is high.
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted.
- done  out  NUM_REQ  one-hot, one-cycle pulse: frame for requester i finished on the wire.
- tx_start  out  1  one-cycle start pulse to uart_tx.
- tx_data  out  8  byte to uart_tx; held stable from the tx_start cycle until the next grant.
- tx_active  in  1  uart_tx busy flag.
- cur_id  out  3  index of the requester currently or last served.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  one-cycle pulse when tx_active never rose within ACK_TIMEOUT.

Behaviour:
- Reset (async assert, reset=0): state=IDLE.
  - All outputs cleared: gnt, done, tx_start, tx_data, cur_id, busy, err_timeout = 0.
  - Internal last_id = NUM_REQ-1, so requester 0 wins first.
  - Counters = 0.
  - Reset released synchronously to clk.
  - Reset mid-frame aborts tracking immediately: no done pulse, no err pulse. The shared uart_tx reset is outside this block.
- All outputs are registered. gnt, done, tx_start and err_timeout are high for exactly one cycle.
- States: IDLE, WAIT_ACT, SENDING, GAP.
- IDLE:
  - Launch condition: req != 0 and tx_active == 0. If tx_active == 1, hold in IDLE with no grant (foreign or late activity).
  - Winner: first set bit of req scanning (last_id+1) mod NUM_REQ upward, wrapping.
  - On the launching edge, all of the following register:
    - tx_data = winner byte;
    - tx_start = 1;
    - gnt[winner] = 1;
    - cur_id = winner;
    - last_id = winner;
    - wait counter cleared;
    - state -> WAIT_ACT.
  - Latency: req asserted at edge N (sampled in IDLE) gives gnt and tx_start high in cycle N+1.
- WAIT_ACT: counter increments each cycle.
  - If tx_active == 1: state -> SENDING.
  - Else if counter == ACK_TIMEOUT-1: err_timeout = 1, state -> GAP, and no done pulse.
  - If tx_active rises in the same cycle the counter hits its limit, SENDING wins and there is no error.
- SENDING: on the first cycle tx_active == 0, done[cur_id] = 1 and state -> GAP with the gap counter cleared.
  - No timeout in this state; frame length is set by uart_tx (10 bits x 16 ticks).
- GAP:
  - Count GAP_CYCLES cycles, then -> IDLE.
  - If GAP_CYCLES == 0, leave GAP after 1 cycle; GAP always lasts at least 1 cycle.
  - Requests arriving during any non-IDLE state are held off, not lost, since the requester keeps req high.
- Requester rules:
  - A requester holding req high after its gnt is treated as a new request and re-arbitrated fairly.
  - Deasserting req before gnt withdraws the request with no side effects.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 frames.
- Simultaneous events: done and the next gnt never occur in the same cycle, because GAP separates them. err_timeout and done are mutually exclusive per frame.
- cur_id upper bits are zero when NUM_REQ <= 4.

Test Plan:
- Single request: req=4'b0001, byte 0x55, uart_tx attached with THRESHOLD=10.
  - gnt=0001 and tx_start one cycle after req.
  - tx_wire carries 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop).
  - done=0001 after tx_active falls; loopback rx_data=0x55.
- Simultaneous requests: req=4'b0101, bytes 0xA1 (id0) and 0xC3 (id2).
  - Grant order 0 then 2.
  - Second tx_start at least GAP_CYCLES+1 cycles after first done.
  - rx_done twice with 0xA1 then 0xC3.
- Continuous requests: req=4'b1111 held for 5 frames.
  - gnt sequence 0001, 0010, 0100, 1000, 0001.
  - cur_id sequence 0, 1, 2, 3, 0.
- Timeout: tx_active tied 0, req=4'b0010.
  - err_timeout pulses exactly ACK_TIMEOUT cycles after tx_start.
  - No done pulse; busy returns 0 after GAP; next grant goes to id 1 again if req is still held.
- Blocked launch: tx_active forced 1 while in IDLE with req=4'b0001.
  - No gnt and no tx_start until tx_active=0.
  - gnt then follows one cycle later.
- Reset mid-frame: assert reset=0 in SENDING.
  - All outputs 0 asynchronously and state IDLE.
  - After release with req=4'b0100, requester 2 is granted; last_id was reset, so a simultaneous req 0 would win instead.
